// File: rtl/rr_hold_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter_if
//   Bundles the request/grant signals between the requesters and the
//   round-robin hold arbiter.
//
//   Signals:
//     req        requesters -> arbiter   level request, one bit per requester
//     gnt        arbiter -> requesters   one-hot registered grant
//     gnt_valid  arbiter -> requesters   any grant active (|gnt)
//     gnt_id     arbiter -> requesters   index of current owner, 0 when idle
//     hold_cnt   arbiter -> requesters   cycles the owner has held gnt
//     timeout    arbiter -> requesters   1-cycle pulse after a forced revoke
//
//   Modports:
//     master  requester side (drives req)
//     slave   arbiter side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface rr_hold_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout;

  modport master (
    output req,
    input  gnt, gnt_valid, gnt_id, hold_cnt, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_id, hold_cnt, timeout
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
//   Round-robin arbiter for one shared registered resource. A grant is held
//   while the owner keeps its request up, for at most MAX_HOLD cycles, and
//   every grant is followed by exactly one dead (GAP) cycle. All outputs are
//   registered; there is no combinational path from req to gnt.
//
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      rr_hold_arbiter_if.slave (req in; gnt, gnt_valid, gnt_id,
//              hold_cnt, timeout out)
// ---------------------------------------------------------------------------
module rr_hold_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4,
  parameter int ID_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  rr_hold_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_reg,    state_next;
  logic [ID_W-1:0]    last_reg,     last_next;
  logic [NUM_REQ-1:0] gnt_reg,      gnt_next;
  logic [ID_W-1:0]    gnt_id_reg,   gnt_id_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic               timeout_reg,  timeout_next;

  // Rotating-priority search: the candidate right after the last winner has
  // the highest priority and the last winner itself the lowest, so a sole
  // requester is still regranted.
  logic            found;
  logic [ID_W-1:0] winner;
  int              idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_reg) + i) % NUM_REQ;
      if (!found && bus.req[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE, GAP: begin
        if (found) begin
          state_next    = GRANT;
          gnt_next      = NUM_REQ'(1) << winner;
          gnt_id_next   = winner;
          hold_cnt_next = CNT_W'(1);
          last_next     = winner;
        end else begin
          state_next    = IDLE;
          gnt_next      = '0;
          gnt_id_next   = '0;
          hold_cnt_next = '0;
        end
      end

      GRANT: begin
        if (!bus.req[gnt_id_reg]) begin
          // Voluntary release, including a drop on the MAX_HOLD edge.
          state_next    = GAP;
          gnt_next      = '0;
          gnt_id_next   = '0;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == CNT_W'(MAX_HOLD)) begin
          state_next    = GAP;
          gnt_next      = '0;
          gnt_id_next   = '0;
          hold_cnt_next = '0;
          timeout_next  = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        gnt_id_next   = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      last_reg     <= ID_W'(NUM_REQ - 1);
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_valid = |gnt_reg;
  assign bus.gnt_id    = gnt_id_reg;
  assign bus.hold_cnt  = hold_cnt_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_hold_arbiter
//   Directed bench for rr_hold_arbiter: a vector table for single grants,
//   the MAX_HOLD release boundary and ignored non-owner requests, followed by
//   hand-written sequences for async reset, full rotation and sole requester.
// ---------------------------------------------------------------------------
module tb_rr_hold_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;
  localparam int ID_W     = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  rr_hold_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  rr_hold_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (CNT_W),
    .ID_W    (ID_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [3:0] cnt;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] r, input logic [3:0] g,
                         input logic [1:0] id, input logic [3:0] c,
                         input logic to);
    vec_t v;
    v.req = r; v.gnt = g; v.id = id; v.cnt = c; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g,
                           input logic [1:0] id, input logic [3:0] c,
                           input logic to);
    $display("[TB] %s req=%b gnt=%b id=%0d cnt=%0d to=%b", tag, bus.req,
             bus.gnt, bus.gnt_id, bus.hold_cnt, bus.timeout);
    check({tag, " gnt"},       32'(bus.gnt),       32'(g));
    check({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
    check({tag, " gnt_id"},    32'(bus.gnt_id),    32'(id));
    check({tag, " hold_cnt"},  32'(bus.hold_cnt),  32'(c));
    check({tag, " timeout"},   32'(bus.timeout),   32'(to));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Structural invariants sampled on the falling edge while out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      check("inv onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
      check("inv gnt_valid", 32'(bus.gnt_valid), 32'(|bus.gnt));
      if (bus.gnt == '0) begin
        check("inv idle id", 32'(bus.gnt_id), 32'(0));
        check("inv idle cnt", 32'(bus.hold_cnt), 32'(0));
      end
    end
  end

  initial begin
    // Vector table: {req applied, expected outputs after the next edge}.
    // Single grant to 2, release after three cycles, then GAP and IDLE.
    add_vec(4'b0100, 4'b0100, 2, 1, 0);
    add_vec(4'b0100, 4'b0100, 2, 2, 0);
    add_vec(4'b0100, 4'b0100, 2, 3, 0);
    for (int i = 0; i < 3; i++) add_vec(4'b0000, 4'b0000, 0, 0, 0);
    // Owner 1 runs to MAX_HOLD and drops req on that very edge: no timeout.
    for (int c = 1; c <= MAX_HOLD; c++) add_vec(4'b0010, 4'b0010, 1, 4'(c), 0);
    add_vec(4'b0000, 4'b0000, 0, 0, 0);
    add_vec(4'b0000, 4'b0000, 0, 0, 0);
    // last=1: 3 beats 1; a late request from 0 is ignored during the grant.
    add_vec(4'b1010, 4'b1000, 3, 1, 0);
    add_vec(4'b1011, 4'b1000, 3, 2, 0);
    add_vec(4'b0011, 4'b0000, 0, 0, 0);
    add_vec(4'b0011, 4'b0001, 0, 1, 0);
    add_vec(4'b0000, 4'b0000, 0, 0, 0);
    add_vec(4'b0000, 4'b0000, 0, 0, 0);

    // T1: reset held with all requests up.
    bus.req = 4'hF;
    reset_n = 1'b0;
    repeat (3) tick();
    check_all("T1 reset", 4'b0000, 0, 0, 0);
    reset_n = 1'b1;
    bus.req = 4'h0;
    tick();
    check_all("T1 idle", 4'b0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req = vecs[i].req;
      tick();
      check_all($sformatf("V%0d", i), vecs[i].gnt, vecs[i].id,
                vecs[i].cnt, vecs[i].to);
    end

    // T5: last=0, so owner 1 wins; reset asynchronously at hold_cnt=5.
    bus.req = 4'hF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_all($sformatf("T5 hold%0d", c), 4'b0010, 1, 4'(c), 0);
    end
    #3;
    reset_n = 1'b0;
    #1;
    check_all("T5 async", 4'b0000, 0, 0, 0);
    tick();
    check_all("T5 in reset", 4'b0000, 0, 0, 0);
    reset_n = 1'b1;

    // T3: rotation 0,1,2,3,0 with req=F, each 8 cycles then timeout GAP.
    for (int r = 0; r < 5; r++) begin
      int o;
      o = r % NUM_REQ;
      for (int c = 1; c <= MAX_HOLD; c++) begin
        tick();
        check_all($sformatf("T3 own%0d c%0d", o, c), 4'(1 << o), 2'(o),
                  4'(c), 0);
      end
      tick();
      check_all($sformatf("T3 gap%0d", r), 4'b0000, 0, 0, 1);
    end
    bus.req = 4'h0;
    tick();
    check_all("T3 idle", 4'b0000, 0, 0, 0);

    // T6: sole requester 1 is regranted after timeout and one GAP cycle.
    bus.req = 4'b0010;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      check_all($sformatf("T6 c%0d", c), 4'b0010, 1, 4'(c), 0);
    end
    tick();
    check_all("T6 gap", 4'b0000, 0, 0, 1);
    tick();
    check_all("T6 regrant", 4'b0010, 1, 1, 0);
    bus.req = 4'h0;
    tick();
    check_all("T6 release", 4'b0000, 0, 0, 0);
    tick();
    check_all("T6 idle", 4'b0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
